// File: rtl/expr_pkg.sv
// Shared definitions for the streaming expression checker.
//   - ASCII constants for digits, operators and parentheses
//   - operator-mask bit positions
//   - FSM state encoding and character-class encoding
package expr_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;

    localparam int OPB_PLUS  = 0;
    localparam int OPB_STAR  = 1;
    localparam int OPB_MINUS = 2;
    localparam int OPB_SLASH = 3;

    typedef enum logic [1:0] {
        ST_EXP = 2'd0,
        ST_NUM = 2'd1,
        ST_CLS = 2'd2,
        ST_ERR = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CC_DIG = 3'd0,
        CC_OP  = 3'd1,
        CC_LP  = 3'd2,
        CC_RP  = 3'd3,
        CC_BAD = 3'd4
    } char_class_e;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier.
//   i_char    : ASCII character
//   i_op_mask : enabled operators (bit0 '+', bit1 '*', bit2 '-', bit3 '/')
//   o_class   : DIG / OP / LP / RP / BAD; a disabled operator is BAD
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  i_char,
    input  logic [3:0]  i_op_mask,
    output char_class_e o_class
);

    always_comb begin
        o_class = CC_BAD;
        if (i_char >= CH_0 && i_char <= CH_9)
            o_class = CC_DIG;
        else if (i_char == CH_LP)
            o_class = CC_LP;
        else if (i_char == CH_RP)
            o_class = CC_RP;
        else if ((i_char == CH_PLUS  && i_op_mask[OPB_PLUS])  ||
                 (i_char == CH_STAR  && i_op_mask[OPB_STAR])  ||
                 (i_char == CH_MINUS && i_op_mask[OPB_MINUS]) ||
                 (i_char == CH_SLASH && i_op_mask[OPB_SLASH]))
            o_class = CC_OP;
    end

endmodule

// File: rtl/expr_paren_checker.sv
// Streaming arithmetic-expression validator with nested parentheses.
//   i_clk      : clock, all updates on rising edge
//   i_clr      : synchronous active-high clear (overrides i_in_valid)
//   i_in       : ASCII character
//   i_in_valid : i_in is consumed on an edge only when high
//   o_out      : consumed string is a complete valid expression
//   o_err      : sticky illegal-sequence flag
//   o_depth    : current open-parenthesis count
//   o_char_cnt : characters consumed without error, saturating
//
// state | meaning
// EXP   | expecting an operand (digit or '(')
// NUM   | inside a numeric operand
// CLS   | just after ')'
// ERR   | illegal sequence seen, absorbing until clear
module expr_paren_checker
    import expr_pkg::*;
#(
    parameter int         MAX_DEPTH   = 4,
    parameter int         DEPTH_W     = 4,
    parameter int         MULTI_DIGIT = 1,
    parameter logic [3:0] OP_MASK     = 4'b0011,
    parameter int         CNT_W       = 8
) (
    input  logic               i_clk,
    input  logic               i_clr,
    input  logic [7:0]         i_in,
    input  logic               i_in_valid,
    output logic               o_out,
    output logic               o_err,
    output logic [DEPTH_W-1:0] o_depth,
    output logic [CNT_W-1:0]   o_char_cnt
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};

    state_e             r_state;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_out;
    logic               r_err;
    logic [CNT_W-1:0]   r_char_cnt;

    char_class_e        w_class;
    state_e             w_next_state;
    logic [DEPTH_W-1:0] w_next_depth;

    expr_char_class u_class (
        .i_char    (i_in),
        .i_op_mask (OP_MASK),
        .o_class   (w_class)
    );

    // Depth changes only on legal transitions; an over/underflow attempt
    // goes to ERR and leaves depth where it was.
    always_comb begin
        w_next_state = ST_ERR;
        w_next_depth = r_depth;
        case (r_state)
            ST_EXP: begin
                if (w_class == CC_DIG) begin
                    w_next_state = ST_NUM;
                end else if (w_class == CC_LP && r_depth != DEPTH_MAX) begin
                    w_next_state = ST_EXP;
                    w_next_depth = r_depth + DEPTH_W'(1);
                end
            end
            ST_NUM: begin
                if (w_class == CC_DIG && MULTI_DIGIT != 0) begin
                    w_next_state = ST_NUM;
                end else if (w_class == CC_OP) begin
                    w_next_state = ST_EXP;
                end else if (w_class == CC_RP && r_depth != '0) begin
                    w_next_state = ST_CLS;
                    w_next_depth = r_depth - DEPTH_W'(1);
                end
            end
            ST_CLS: begin
                if (w_class == CC_OP) begin
                    w_next_state = ST_EXP;
                end else if (w_class == CC_RP && r_depth != '0) begin
                    w_next_state = ST_CLS;
                    w_next_depth = r_depth - DEPTH_W'(1);
                end
            end
            default: begin
                w_next_state = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state    <= ST_EXP;
            r_depth    <= '0;
            r_out      <= 1'b0;
            r_err      <= 1'b0;
            r_char_cnt <= '0;
        end else if (i_in_valid) begin
            r_state <= w_next_state;
            r_depth <= w_next_depth;
            r_out   <= (w_next_state == ST_NUM || w_next_state == ST_CLS) &&
                       (w_next_depth == '0);
            r_err   <= (w_next_state == ST_ERR);
            // The offending character and anything after it is not counted.
            if (w_next_state != ST_ERR && r_char_cnt != CNT_SAT)
                r_char_cnt <= r_char_cnt + CNT_W'(1);
        end
    end

    assign o_out      = r_out;
    assign o_err      = r_err;
    assign o_depth    = r_depth;
    assign o_char_cnt = r_char_cnt;

endmodule
